cic_comp_fir: RTL
=================

CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, sample width (signed).
REQ-002 The block SHALL have parameter DATA_FRAC, default 15, sample fraction bits.
REQ-003 The block SHALL have parameter COEFF_WIDTH, default 16, coefficient width, signed Q1.(COEFF_WIDTH-1).
REQ-004 The block SHALL have parameter NUM_TAPS, default 15, which must be odd, in the range 3..63.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port valid_in, input, 1 bit: fir_in valid, driven from the decimator output.
REQ-008 The block SHALL have port bypass, input, 1 bit: pass-through mode.
REQ-009 The block SHALL have port fir_in, input, DATA_WIDTH bits: signed sample.
REQ-010 The block SHALL have port coeff_wr_en, input, 1 bit: coefficient write strobe.
REQ-011 The block SHALL have port coeff_addr, input, 6 bits: coefficient index.
REQ-012 The block SHALL have port coeff_data, input, COEFF_WIDTH bits: coefficient value.
REQ-013 The block SHALL have port fir_out, output, DATA_WIDTH bits: filtered sample.
REQ-014 The block SHALL have port valid_out, output, 1 bit: one-cycle fir_out valid pulse.
REQ-015 The block SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.
REQ-016 The block SHALL have output pulse ports sample_drop, coeff_wr_err, overflow and underflow, 1 bit each.

Function
REQ-017 The block SHALL keep a NUM_TAPS-deep delay line x[0..NUM_TAPS-1]; on accept, x[0] takes fir_in and x[k] takes the old x[k-1].
REQ-018 The FSM SHALL have states IDLE, MAC and ROUND, and SHALL accept a sample only when it is in IDLE with valid_in=1, then go IDLE->MAC.
REQ-019 In MAC, one multiply-accumulate per cycle SHALL form acc = sum c[k]*x[k] over M cycles, then go MAC->ROUND; ROUND SHALL go ->IDLE after one cycle.
REQ-020 The accumulator SHALL be DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS) bits, sign-extended, with no internal wrap.
REQ-021 ROUND SHALL add 2^(COEFF_WIDTH-2), arithmetic-shift right by COEFF_WIDTH-1, and saturate to DATA_WIDTH bits.
REQ-022 On positive clip, ROUND SHALL output 0x7FFF with overflow=1; on negative clip, 0x8000 with underflow=1; both flags are coincident with valid_out.
REQ-023 valid_out SHALL be high exactly one cycle, M+1 cycles after the accepting edge; fir_out SHALL hold its value until the next valid_out.
REQ-024 A valid_in while busy=1 SHALL be discarded, with the delay line unchanged and sample_drop high for one cycle.
REQ-025 A valid_in in the same cycle as ROUND->IDLE SHALL be dropped, because the state is still ROUND.
REQ-026 A coefficient write SHALL be applied on the next edge when busy=0.
REQ-027 A coefficient write while busy=1, or to an out-of-range address, SHALL be ignored and raise coeff_wr_err for one cycle.
REQ-028 When bypass=1: fir_out<=fir_in and valid_out<=valid_in (1-cycle latency), flags=0, FSM forced to IDLE, delay line frozen.
REQ-029 Deasserting bypass mid-MAC SHALL not resume the aborted sample.

Reset
REQ-030 rst_n=0 SHALL clear fir_out, valid_out, busy, sample_drop, coeff_wr_err, overflow, underflow, the accumulator and the delay line to 0, and set the FSM to IDLE.
REQ-031 Reset SHALL set all coefficients to 0, except the centre tap c[(NUM_TAPS-1)/2] = 0x7FFF (impulse).
REQ-032 Reset asserted mid-MAC SHALL abort the sample; no valid_out SHALL occur for it after release.

Configuration
REQ-033 With CIC_COMP_SYM_FOLD_EN defined, only c[0..(NUM_TAPS-1)/2] SHALL be stored, with coefficients symmetric.
REQ-034 With CIC_COMP_SYM_FOLD_EN defined, each MAC cycle SHALL use the pre-add x[k]+x[NUM_TAPS-1-k] at DATA_WIDTH+1 bits; the centre tap SHALL use x[centre] alone.
REQ-035 With CIC_COMP_SYM_FOLD_EN defined, M = (NUM_TAPS+1)/2 and the valid address range is 0..(NUM_TAPS-1)/2.
REQ-036 Without CIC_COMP_SYM_FOLD_EN, NUM_TAPS independent coefficients SHALL be stored, M = NUM_TAPS, and the valid address range is 0..NUM_TAPS-1.

Verification
REQ-037 Impulse: after reset, send 0x4000 then zeros -> fir_out=0x4000 on the 8th valid_out (counting from 1), 0 on all others.
REQ-038 Latency: accept at edge E0 -> valid_out high after E16 (no fold) or E9 (fold), NUM_TAPS=15.
REQ-039 Saturation: write all coeffs 0x7FFF, drive 0x7FFF continuously -> fir_out=0x7FFF with overflow=1; with 0x8000 input -> fir_out=0x8000 with underflow=1.
REQ-040 Drop: valid_in on two consecutive cycles -> second sample gives sample_drop=1, one valid_out only, delay line holds only the first sample.
REQ-041 Coeff error: write while busy=1, or to address 15 (no fold) or 8 (fold) -> coeff_wr_err=1 and the coefficient is unchanged on readback via impulse response.
REQ-042 Reset mid-operation: assert rst_n=0 at MAC cycle 5, release -> all outputs 0, no valid_out; the next 0x4000 impulse reproduces REQ-037.

Source files
------------

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - CIC droop-compensation FIR, one MAC per cycle, programmable taps
//
// Optional feature macro: CIC_COMP_SYM_FOLD_EN (symmetric coefficient folding).
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   valid_in        fir_in qualifier from the decimator
//   bypass          pass fir_in/valid_in straight to the outputs with one cycle of latency
//   fir_in          signed input sample
//   coeff_wr_en     coefficient write strobe, honoured only while idle
//   coeff_addr      coefficient index
//   coeff_data      coefficient value, signed Q1.(COEFF_WIDTH-1)
//   fir_out         filtered sample, held between valid_out pulses
//   valid_out       one-cycle result strobe
//   busy            filter is working on a sample
//   sample_drop     a valid_in arrived while busy and was discarded
//   coeff_wr_err    a coefficient write was rejected (busy or bad address)
//   overflow        result clipped to the positive limit
//   underflow       result clipped to the negative limit
// DATA_FRAC documents the sample format; input and output share it.
module cic_comp_fir #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA_FRAC   = 15,
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_TAPS    = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic                   bypass,
    input  logic [DATA_WIDTH-1:0]  fir_in,
    input  logic                   coeff_wr_en,
    input  logic [5:0]             coeff_addr,
    input  logic [COEFF_WIDTH-1:0] coeff_data,
    output logic [DATA_WIDTH-1:0]  fir_out,
    output logic                   valid_out,
    output logic                   busy,
    output logic                   sample_drop,
    output logic                   coeff_wr_err,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int CENTRE = (NUM_TAPS - 1) / 2;
`ifdef CIC_COMP_SYM_FOLD_EN
    localparam int NUM_COEF = (NUM_TAPS + 1) / 2;
`else
    localparam int NUM_COEF = NUM_TAPS;
`endif
    localparam int ACC_W  = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_WIDTH + 1 + COEFF_WIDTH;

    localparam logic [COEFF_WIDTH-1:0] COEF_ONE = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]  OUT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]  OUT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W-1){1'b0}}, 1'b1} << (COEFF_WIDTH - 2);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                         state_q, state_d;
    logic        [5:0]              idx;
    logic signed [ACC_W-1:0]        acc;
    logic signed [DATA_WIDTH-1:0]   x     [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0]  coeff [NUM_COEF];
    logic signed [DATA_WIDTH:0]     tap_x;
    logic signed [COEFF_WIDTH-1:0]  tap_c;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        acc_rnd, acc_sh;
    logic                           addr_ok;

    assign busy    = (state_q != IDLE);
    assign addr_ok = (coeff_addr < 6'(NUM_COEF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Bypass overrides everything and parks the FSM, so a sample being
    // processed when bypass rises is abandoned.
    always_comb begin
        state_d = state_q;
        if (bypass) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (valid_in) state_d = MAC;
                MAC:     if (idx == 6'(NUM_COEF - 1)) state_d = ROUND;
                ROUND:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operand select for the current MAC step. With folding, the mirrored
    // taps are pre-added so one multiply covers both halves.
    always_comb begin
        tap_x = '0;
        tap_c = '0;
        for (int k = 0; k < NUM_COEF; k++) begin
            if (idx == 6'(k)) begin
                tap_c = coeff[k];
`ifdef CIC_COMP_SYM_FOLD_EN
                if (k == CENTRE)
                    tap_x = {x[k][DATA_WIDTH-1], x[k]};
                else
                    tap_x = {x[k][DATA_WIDTH-1], x[k]}
                          + {x[NUM_TAPS-1-k][DATA_WIDTH-1], x[NUM_TAPS-1-k]};
`else
                tap_x = {x[k][DATA_WIDTH-1], x[k]};
`endif
            end
        end
    end

    assign prod    = tap_x * tap_c;
    assign acc_rnd = acc + RND_HALF;
    assign acc_sh  = acc_rnd >>> (COEFF_WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fir_out      <= '0;
            valid_out    <= 1'b0;
            sample_drop  <= 1'b0;
            coeff_wr_err <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            acc          <= '0;
            idx          <= '0;
            for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
        end else begin
            valid_out    <= 1'b0;
            sample_drop  <= 1'b0;
            coeff_wr_err <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            if (bypass) begin
                fir_out   <= fir_in;
                valid_out <= valid_in;
            end else begin
                sample_drop  <= valid_in && busy;
                coeff_wr_err <= coeff_wr_en && (busy || !addr_ok);
                case (state_q)
                    IDLE: begin
                        if (valid_in) begin
                            x[0] <= fir_in;
                            for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
                            acc <= '0;
                            idx <= '0;
                        end
                    end
                    MAC: begin
                        acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                        idx <= idx + 6'd1;
                    end
                    ROUND: begin
                        valid_out <= 1'b1;
                        if (acc_sh > SAT_MAX) begin
                            fir_out  <= OUT_MAX;
                            overflow <= 1'b1;
                        end else if (acc_sh < SAT_MIN) begin
                            fir_out   <= OUT_MIN;
                            underflow <= 1'b1;
                        end else begin
                            fir_out <= acc_sh[DATA_WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Coefficient RAM; reset loads a unity impulse on the centre tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_COEF; k++)
                coeff[k] <= (k == CENTRE) ? COEF_ONE : '0;
        end else if (coeff_wr_en && !busy && addr_ok) begin
            for (int k = 0; k < NUM_COEF; k++)
                if (coeff_addr == 6'(k)) coeff[k] <= coeff_data;
        end
    end

endmodule
